// File: rtl/header_ram_reader.sv
// Port-B block read sequencer for the header RAM, streaming words through a 2-entry FIFO.
// Optional block checksum on xsum when HEADER_RD_XSUM_EN is defined; otherwise xsum is 0.
module header_ram_reader #(
    parameter int RAM_WIDTH = 9,
    parameter int RAM_ADRB  = 11,
    parameter int CNT_BITS  = RAM_ADRB + 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [RAM_ADRB-1:0]  start_adr,
    input  logic [CNT_BITS-1:0]  nwords,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_enb,
    output logic [RAM_ADRB-1:0]  rd_adrb,
    input  logic [RAM_WIDTH-1:0] rd_datab,
    output logic [RAM_WIDTH-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic [RAM_WIDTH-1:0] xsum
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           r_state;
    logic [RAM_ADRB-1:0]  r_adr;
    logic [CNT_BITS-1:0]  r_nwords;
    logic [CNT_BITS-1:0]  r_issued;
    logic [CNT_BITS-1:0]  r_delivered;
    logic                 r_inflight;
    logic [RAM_WIDTH-1:0] r_fifo [2];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;

    logic w_accept, w_credit, w_issue, w_has_head, w_valid, w_xfer, w_last, w_push, w_pop;

    assign w_accept   = (r_state == S_IDLE) && start && !abort;
    assign w_credit   = (r_count == 2'd0) || ((r_count == 2'd1) && !r_inflight);
    assign w_issue    = (r_state == S_READ) && !abort && (r_issued < r_nwords) && w_credit;
    assign w_has_head = (r_count != 2'd0);
    // A returning word bypasses the empty FIFO so the stream sees it in the return cycle.
    assign w_valid    = w_has_head || r_inflight;
    assign w_xfer     = w_valid && dout_ready;
    assign w_last     = w_valid && ((r_delivered + CNT_BITS'(1)) == r_nwords);
    assign w_push     = r_inflight && !(w_xfer && !w_has_head);
    assign w_pop      = w_xfer && w_has_head;

    assign busy       = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign rd_enb     = w_issue;
    assign rd_adrb    = r_adr;
    assign dout_valid = w_valid;
    assign dout_last  = w_last;
    assign dout       = w_has_head ? r_fifo[r_rptr] : (r_inflight ? rd_datab : '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_adr       <= '0;
            r_nwords    <= '0;
            r_issued    <= '0;
            r_delivered <= '0;
            r_inflight  <= 1'b0;
            r_fifo      <= '{default: '0};
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
        end else if (abort) begin
            r_state    <= S_IDLE;
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_adr    <= r_adr + RAM_ADRB'(1);
                r_issued <= r_issued + CNT_BITS'(1);
            end
            if (w_xfer) r_delivered <= r_delivered + CNT_BITS'(1);
            if (w_push) begin
                r_fifo[r_wptr] <= rd_datab;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_adr       <= start_adr;
                        r_nwords    <= nwords;
                        r_issued    <= '0;
                        r_delivered <= '0;
                        r_state     <= (nwords == '0) ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (w_issue && ((r_issued + CNT_BITS'(1)) == r_nwords)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // The final transfer implies nothing in flight and the FIFO empty.
                    if (w_xfer && w_last) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HEADER_RD_XSUM_EN
    logic [RAM_WIDTH-1:0] r_xsum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    r_xsum <= '0;
        else if (w_accept) r_xsum <= '0;
        else if (w_xfer)   r_xsum <= r_xsum ^ dout;
    end

    assign xsum = r_xsum;
`else
    assign xsum = '0;
`endif

endmodule

// File: tb/tb_header_ram_reader.sv
// Directed bench for header_ram_reader: behavioural RAM with 1-cycle read latency,
// stream monitor on the falling edge, and hand-computed expectations.
module tb_header_ram_reader;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] start_adr = '0;
    logic [11:0] nwords = '0;
    logic        abort = 1'b0;
    logic        busy, done, rd_enb;
    logic [10:0] rd_adrb;
    logic [8:0]  rd_datab = '0;
    logic [8:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        dout_last;
    logic [8:0]  xsum;

    header_ram_reader #(.RAM_WIDTH(9), .RAM_ADRB(11), .CNT_BITS(12)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .start_adr(start_adr),
        .nwords(nwords), .abort(abort), .busy(busy), .done(done), .rd_enb(rd_enb),
        .rd_adrb(rd_adrb), .rd_datab(rd_datab), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .xsum(xsum)
    );

    always #5 clock = ~clock;

    logic [8:0] mem [2048];
    always @(posedge clock) if (rd_enb) rd_datab <= mem[rd_adrb];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor state
    logic [10:0] q_adr[$];
    logic [8:0]  q_out[$];
    logic        q_last[$];
    int n_rd, n_valid, n_done, xfers, issued_tot, max_out, stall_err, post_abort;
    int first_vld, last_xfer, done_cyc, abort_cyc, st_cyc;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_dout = '0;
    logic       prev_last = 1'b0;

    task automatic clr();
        q_adr.delete(); q_out.delete(); q_last.delete();
        n_rd = 0; n_valid = 0; n_done = 0; xfers = 0; issued_tot = 0; max_out = 0;
        stall_err = 0; post_abort = 0; first_vld = -1; last_xfer = -1; done_cyc = -1;
        abort_cyc = -1;
    endtask

    always @(negedge clock) if (reset_n) begin
        if (rd_enb) begin
            q_adr.push_back(rd_adrb);
            n_rd++;
            issued_tot++;
        end
        if (issued_tot - xfers > max_out) max_out = issued_tot - xfers;
        if (dout_valid) begin
            n_valid++;
            if (first_vld < 0) first_vld = cyc;
        end
        if (dout_valid && dout_ready) begin
            q_out.push_back(dout);
            q_last.push_back(dout_last);
            last_xfer = cyc;
            xfers++;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (prev_stall && (!dout_valid || dout !== prev_dout || dout_last !== prev_last)) stall_err++;
        prev_stall = dout_valid && !dout_ready;
        prev_dout  = dout;
        prev_last  = dout_last;
        if (abort_cyc >= 0 && cyc > abort_cyc && (rd_enb || dout_valid || done || busy)) post_abort++;
    end

    logic tog = 1'b0;
    int   ti = 0;
    int   pat [6] = '{1, 0, 0, 1, 0, 1};

    task automatic step();
        @(posedge clock);
        #1;
        if (tog) begin
            dout_ready = pat[ti % 6] != 0;
            ti++;
        end
    endtask

    task automatic start_blk(input logic [10:0] a, input logic [11:0] n);
        start_adr = a;
        nwords    = n;
        start     = 1'b1;
        st_cyc    = cyc;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (n_done > 0) break;
        end
        step();
        step();
    endtask

    task automatic chk_block(input string tag, input logic [10:0] base, input int n);
        chk({tag, "_nxfer"}, xfers, n);
        for (int i = 0; i < n && i < q_out.size(); i++) begin
            chk({tag, "_word"}, q_out[i], mem[11'(base + 11'(i))]);
            chk({tag, "_last"}, q_last[i], (i == n - 1) ? 1 : 0);
        end
        chk({tag, "_ndone"}, n_done, 1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 9'((i * 37 + 5) ^ (i >> 3));
        mem[11'h010] = 9'h101;
        mem[11'h011] = 9'h0A2;
        mem[11'h012] = 9'h1F3;
        mem[11'h013] = 9'h004;
        clr();

        // Reset values
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_enb", rd_enb, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_last", dout_last, 0);
        chk("rst_adrb", rd_adrb, 0);
        chk("rst_dout", dout, 0);
        chk("rst_xsum", xsum, 0);
        reset_n = 1'b1;
        step(); step();

        // A: basic block, full throughput
        clr();
        start_blk(11'h010, 12'd4);
        chk("A_busy", busy, 1);
        wait_done(40);
        chk("A_nrd", n_rd, 4);
        for (int i = 0; i < 4 && i < q_adr.size(); i++) chk("A_adr", q_adr[i], 32'h10 + i);
        chk("A_w0", q_out.size() > 0 ? q_out[0] : 9'h0, 9'h101);
        chk("A_w1", q_out.size() > 1 ? q_out[1] : 9'h0, 9'h0A2);
        chk("A_w2", q_out.size() > 2 ? q_out[2] : 9'h0, 9'h1F3);
        chk("A_w3", q_out.size() > 3 ? q_out[3] : 9'h0, 9'h004);
        chk_block("A", 11'h010, 4);
        chk("A_first_vld", first_vld - st_cyc, 2);
        chk("A_burst_len", last_xfer - first_vld, 3);
        chk("A_done_lat", done_cyc - last_xfer, 1);
        chk("A_busy_after", busy, 0);
`ifdef HEADER_RD_XSUM_EN
        chk("A_xsum", xsum, 9'h054);
`else
        chk("A_xsum", xsum, 9'h000);
`endif

        // B: address wrap
        clr();
        start_blk(11'h7FE, 12'd4);
        wait_done(40);
        chk("B_nrd", n_rd, 4);
        chk("B_adr0", q_adr.size() > 0 ? q_adr[0] : 11'h0, 11'h7FE);
        chk("B_adr1", q_adr.size() > 1 ? q_adr[1] : 11'h0, 11'h7FF);
        chk("B_adr2", q_adr.size() > 2 ? q_adr[2] : 11'h1, 11'h000);
        chk("B_adr3", q_adr.size() > 3 ? q_adr[3] : 11'h0, 11'h001);
        chk_block("B", 11'h7FE, 4);

        // C: backpressure 1,0,0,1,0,1...
        clr();
        tog = 1'b1; ti = 0;
        start_blk(11'h100, 12'd6);
        wait_done(100);
        tog = 1'b0; dout_ready = 1'b1;
        chk_block("C", 11'h100, 6);
        chk("C_nrd", n_rd, 6);
        chk("C_credit", max_out <= 2, 1);
        chk("C_stall_stable", stall_err, 0);

        // D: zero-length block
        clr();
        start_blk(11'h055, 12'd0);
        wait_done(20);
        chk("D_ndone", n_done, 1);
        chk("D_done_lat", done_cyc - st_cyc, 1);
        chk("D_nrd", n_rd, 0);
        chk("D_nvalid", n_valid, 0);

        // E: second start while busy is ignored
        clr();
        start_blk(11'h200, 12'd5);
        step();
        start_adr = 11'h300; nwords = 12'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(60);
        chk_block("E", 11'h200, 5);
        chk("E_adr0", q_adr.size() > 0 ? q_adr[0] : 11'h0, 11'h200);

        // F: abort after the 2nd of 8 words, then a fresh block
        clr();
        start_blk(11'h400, 12'd8);
        for (int i = 0; i < 30 && xfers < 2; i++) step();
        chk("F_xfers_pre", xfers, 2);
        abort = 1'b1; dout_ready = 1'b0; abort_cyc = cyc;
        step();
        abort = 1'b0; dout_ready = 1'b1;
        chk("F_busy_next", busy, 0);
        repeat (10) step();
        chk("F_post_abort", post_abort, 0);
        chk("F_ndone", n_done, 0);
        chk("F_xfers", xfers, 2);
        clr();
        start_blk(11'h020, 12'd3);
        wait_done(40);
        chk("F2_adr0", q_adr.size() > 0 ? q_adr[0] : 11'h0, 11'h020);
        chk_block("F2", 11'h020, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
